// File: rtl/updown_pkg.sv
// Shared types and default range constants for the 5-to-31 wrap-around
// up/down counter and its receive-side sequence decoder.
package updown_pkg;

  // Default counter geometry, shared by the counter and the decoder.
  localparam int DEF_WIDTH   = 5;
  localparam int DEF_MIN_VAL = 5;
  localparam int DEF_MAX_VAL = 31;

  // Decoder tracking state.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ACQ       = 2'd1,
    ST_LOCK_UP   = 2'd2,
    ST_LOCK_DOWN = 2'd3
  } state_t;

  // Relationship of a new sample to the previous one.
  typedef enum logic [2:0] {
    STEP_UP    = 3'd0,
    STEP_DOWN  = 3'd1,
    STEP_HOLD  = 3'd2,
    STEP_JUMP  = 3'd3,
    STEP_RANGE = 3'd4
  } step_t;

  // True when a step class is a legal single count in either direction.
  function automatic logic is_count_step(input step_t s);
    return (s == STEP_UP) || (s == STEP_DOWN);
  endfunction

endpackage

// File: rtl/updown_step_classify.sv
// Purely combinational classifier: compares a new counter sample with the
// previous one and reports the step class plus the two wrap conditions.
module updown_step_classify
  import updown_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int MIN_VAL = DEF_MIN_VAL,
  parameter int MAX_VAL = DEF_MAX_VAL
) (
  input  logic [WIDTH-1:0] prev,
  input  logic [WIDTH-1:0] q_in,
  output step_t            step,
  output logic             wrap_up_hit,
  output logic             wrap_down_hit
);

  // One extra bit keeps prev+1 and prev-1 from aliasing back into range.
  localparam logic [WIDTH:0] MIN_X = (WIDTH + 1)'(MIN_VAL);
  localparam logic [WIDTH:0] MAX_X = (WIDTH + 1)'(MAX_VAL);

  logic [WIDTH:0] prev_x;
  logic [WIDTH:0] q_x;
  logic           out_of_range;
  logic           is_up;
  logic           is_down;

  assign prev_x = {1'b0, prev};
  assign q_x    = {1'b0, q_in};

  // Raw comparisons; wrap-around is handled explicitly at the range ends.
  always_comb begin
    out_of_range = (q_x < MIN_X) || (q_x > MAX_X);
    if (prev_x == MAX_X) begin
      is_up = (q_x == MIN_X);
    end else begin
      is_up = (q_x == prev_x + 1'b1);
    end
    if (prev_x == MIN_X) begin
      is_down = (q_x == MAX_X);
    end else begin
      is_down = (q_x == prev_x - 1'b1);
    end
  end

  // Priority resolution: range, then hold, then up, down, and finally jump.
  always_comb begin
    step          = STEP_JUMP;
    wrap_up_hit   = 1'b0;
    wrap_down_hit = 1'b0;
    if (out_of_range) begin
      step = STEP_RANGE;
    end else if (q_in == prev) begin
      step = STEP_HOLD;
    end else if (is_up) begin
      step        = STEP_UP;
      wrap_up_hit = (prev_x == MAX_X);
    end else if (is_down) begin
      step          = STEP_DOWN;
      wrap_down_hit = (prev_x == MIN_X);
    end
  end

endmodule

// File: rtl/updown_seq_decoder.sv
// Receive-side decoder for the wrap-around up/down counter stream. Tracks the
// count direction, locks after a run of consistent steps, and flags wraps,
// loads and protocol errors. All outputs are registered (latency 1).
module updown_seq_decoder
  import updown_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int MIN_VAL  = DEF_MIN_VAL,
  parameter int MAX_VAL  = DEF_MAX_VAL,
  parameter int LOCK_CNT = 2,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [WIDTH-1:0] q_in,
  output logic             locked,
  output logic             dir,
  output logic             dir_change,
  output logic             wrap_up,
  output logic             wrap_down,
  output logic             load_seen,
  output logic             range_err,
  output logic             hold_err,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [2:0] LOCK_RUN = 3'(LOCK_CNT);

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] prev_n;
  logic [2:0]       run;
  logic [2:0]       run_n;
  logic             run_dir;
  logic             run_dir_n;

  logic             locked_n;
  logic             dir_n;
  logic             dir_change_n;
  logic             wrap_up_n;
  logic             wrap_down_n;
  logic             load_seen_n;
  logic             range_err_n;
  logic             hold_err_n;
  logic [ERR_W-1:0] err_cnt_n;

  step_t            step;
  logic             wrap_up_hit;
  logic             wrap_down_hit;
  logic             step_is_up;
  logic [2:0]       run_inc;

  updown_step_classify #(
    .WIDTH   (WIDTH),
    .MIN_VAL (MIN_VAL),
    .MAX_VAL (MAX_VAL)
  ) u_classify (
    .prev          (prev),
    .q_in          (q_in),
    .step          (step),
    .wrap_up_hit   (wrap_up_hit),
    .wrap_down_hit (wrap_down_hit)
  );

  // Run length if this sample is a count step: extend a matching run, else restart at 1.
  always_comb begin
    step_is_up = (step == STEP_UP);
    if (run_dir == step_is_up) begin
      run_inc = run + 3'd1;
    end else begin
      run_inc = 3'd1;
    end
  end

  // Next-state, run counter, pulse and error-counter logic.
  always_comb begin
    state_n      = state;
    prev_n       = prev;
    run_n        = run;
    run_dir_n    = run_dir;
    locked_n     = locked;
    dir_n        = dir;
    dir_change_n = 1'b0;
    wrap_up_n    = 1'b0;
    wrap_down_n  = 1'b0;
    load_seen_n  = 1'b0;
    range_err_n  = 1'b0;
    hold_err_n   = 1'b0;
    err_cnt_n    = err_cnt;

    if (valid) begin
      if (step != STEP_RANGE) begin
        prev_n = q_in;
      end

      if (state != ST_IDLE) begin
        wrap_up_n   = wrap_up_hit;
        wrap_down_n = wrap_down_hit;
      end

      case (state)
        ST_IDLE: begin
          if (step == STEP_RANGE) begin
            range_err_n = 1'b1;
          end else begin
            state_n = ST_ACQ;
            run_n   = 3'd0;
          end
        end

        ST_ACQ: begin
          if (is_count_step(step)) begin
            run_n     = run_inc;
            run_dir_n = step_is_up;
            if (run_inc >= LOCK_RUN) begin
              state_n  = step_is_up ? ST_LOCK_UP : ST_LOCK_DOWN;
              locked_n = 1'b1;
              dir_n    = step_is_up;
            end
          end else if (step == STEP_JUMP) begin
            load_seen_n = 1'b1;
            run_n       = 3'd0;
          end else if (step == STEP_HOLD) begin
            hold_err_n = 1'b1;
            run_n      = 3'd0;
          end else begin
            range_err_n = 1'b1;
            state_n     = ST_IDLE;
            run_n       = 3'd0;
          end
        end

        ST_LOCK_UP, ST_LOCK_DOWN: begin
          if (is_count_step(step)) begin
            if (step_is_up != (state == ST_LOCK_UP)) begin
              state_n      = step_is_up ? ST_LOCK_UP : ST_LOCK_DOWN;
              dir_n        = step_is_up;
              dir_change_n = 1'b1;
            end
          end else if (step == STEP_JUMP) begin
            load_seen_n = 1'b1;
            state_n     = ST_ACQ;
            locked_n    = 1'b0;
            run_n       = 3'd0;
          end else if (step == STEP_HOLD) begin
            hold_err_n = 1'b1;
            state_n    = ST_ACQ;
            locked_n   = 1'b0;
            run_n      = 3'd0;
          end else begin
            range_err_n = 1'b1;
            state_n     = ST_IDLE;
            locked_n    = 1'b0;
            run_n       = 3'd0;
          end
        end

        default: begin
          state_n  = ST_IDLE;
          locked_n = 1'b0;
          run_n    = 3'd0;
        end
      endcase

      if ((range_err_n || hold_err_n) && (err_cnt != {ERR_W{1'b1}})) begin
        err_cnt_n = err_cnt + 1'b1;
      end
    end
  end

  // State and output registers; reset wins over any sample in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      prev       <= '0;
      run        <= 3'd0;
      run_dir    <= 1'b0;
      locked     <= 1'b0;
      dir        <= 1'b0;
      dir_change <= 1'b0;
      wrap_up    <= 1'b0;
      wrap_down  <= 1'b0;
      load_seen  <= 1'b0;
      range_err  <= 1'b0;
      hold_err   <= 1'b0;
      err_cnt    <= '0;
    end else begin
      state      <= state_n;
      prev       <= prev_n;
      run        <= run_n;
      run_dir    <= run_dir_n;
      locked     <= locked_n;
      dir        <= dir_n;
      dir_change <= dir_change_n;
      wrap_up    <= wrap_up_n;
      wrap_down  <= wrap_down_n;
      load_seen  <= load_seen_n;
      range_err  <= range_err_n;
      hold_err   <= hold_err_n;
      err_cnt    <= err_cnt_n;
    end
  end

endmodule

// File: doc/updown_seq_decoder.md
Name: updown_seq_decoder

Overview:
- Receive-side decoder for the 5-to-31 wrap-around up/down counter output stream.
- Samples one counter value per valid cycle and recovers the count direction.
- Reports wrap events, loads (discontinuous jumps) and protocol errors (out-of-range values, stalls).
- Sits downstream of the counter on the same clock; the bench uses it as a scoreboard front-end.

Parameters:
- WIDTH, 5, sample width in bits.
- MIN_VAL, 5, lowest legal count; wrap target for up counting.
- MAX_VAL, 31, highest legal count; wrap target for down counting. Requires MAX_VAL-MIN_VAL >= 2 and MAX_VAL <= 2^WIDTH-1.
- LOCK_CNT, 2, consecutive same-direction steps required to declare lock (1..7).
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- valid  in  1  q_in carries a new counter sample this cycle
- q_in  in  WIDTH  counter sample
- locked  out  1  direction is locked
- dir  out  1  1 = up, 0 = down; meaningful only when locked=1
- dir_change  out  1  one-cycle pulse: locked direction reversed
- wrap_up  out  1  one-cycle pulse: MAX_VAL->MIN_VAL step seen
- wrap_down  out  1  one-cycle pulse: MIN_VAL->MAX_VAL step seen
- load_seen  out  1  one-cycle pulse: in-range discontinuous jump seen
- range_err  out  1  one-cycle pulse: sample below MIN_VAL or above MAX_VAL
- hold_err  out  1  one-cycle pulse: sample equals previous sample
- err_cnt  out  ERR_W  saturating count of range_err plus hold_err events

Behaviour:
- All outputs are registered and update on the clk edge after the valid sample (latency 1). With valid=0, state is held and all pulses are 0.
- Reset: state=IDLE, prev=0, run=0, locked=0, dir=0, all pulses 0, err_cnt=0. Reset mid-stream discards prev and any lock, and takes priority over valid.
- Sample classification, given prev (evaluated in priority order):
  - RANGE: q_in<MIN_VAL or q_in>MAX_VAL.
  - HOLD: q_in==prev.
  - UP: (prev==MAX_VAL and q_in==MIN_VAL) or (prev!=MAX_VAL and q_in==prev+1).
  - DOWN: (prev==MIN_VAL and q_in==MAX_VAL) or (prev!=MIN_VAL and q_in==prev-1).
  - JUMP: any other in-range value.
  - UP and DOWN are mutually exclusive because the range spans at least 3 values.
- States: IDLE (no prev), ACQ (prev held, unlocked), LOCK_UP, LOCK_DOWN. run is a 3-bit run counter with its own direction bit.
- IDLE:
  - RANGE: range_err, stay in IDLE.
  - Otherwise: prev=q_in, go to ACQ, run=0.
- ACQ:
  - UP/DOWN: if the step matches the run direction, run+1; otherwise run=1 with the new direction.
  - When run reaches LOCK_CNT, go to the matching LOCK state with locked=1 and dir set. No dir_change pulse on first lock.
  - JUMP: load_seen, run=0.
  - HOLD: hold_err, run=0.
  - RANGE: range_err, go to IDLE.
- LOCK_x:
  - Same-direction step: stay.
  - Opposite-direction step: move directly to the other LOCK state, dir flips, dir_change pulses. Mode switches are legal.
  - JUMP: load_seen, go to ACQ, locked=0, run=0.
  - HOLD: hold_err, go to ACQ, locked=0.
  - RANGE: range_err, go to IDLE, locked=0.
- prev is updated to q_in on every valid sample except RANGE samples.
- wrap_up and wrap_down pulse on the qualifying step in any non-IDLE state, independent of lock.
- err_cnt increments on each range_err or hold_err and saturates at 2^ERR_W-1.

Decomposition:
- Shared package updown_pkg:
  - state enum (IDLE, ACQ, LOCK_UP, LOCK_DOWN)
  - step-class enum (UP, DOWN, HOLD, JUMP, RANGE)
  - default MIN_VAL/MAX_VAL constants, shared with the counter
- Sub-module updown_step_classify: purely combinational, (prev, q_in) -> step class plus wrap flags. The FSM, run counter and error counter stay in the top level.

Test Plan:
- Reset, then samples 5,6,7,8 -> locked=1 and dir=1 registered after the 7 sample; no errors.
- Up stream 29,30,31,5,6 -> wrap_up pulses exactly once, on the cycle after the 5 sample; lock held.
- Down stream 7,6,5,31,30, then up 31 -> wrap_down pulses after the 31 sample; dir_change pulses after the final 31 and dir=1.
- Locked up at 12, then sample 20 -> load_seen=1, locked=0; then 21,22 -> relock up.
- Samples 10, 3 -> range_err=1, state=IDLE, err_cnt=1; then 10,10 -> hold_err=1, err_cnt=2. Drive 300 errors with ERR_W=8 -> err_cnt stays at 255.
- Locked mid-stream, assert rst with valid=1 -> next cycle all outputs are at reset values and the sample is ignored.
